// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between a data-memory requester and the
// dmem_responder.
//   req_*  : load/store request, valid/ready handshake (requester drives valid and fields)
//   resp_* : load data / store completion, valid/ready handshake (responder drives valid)
// Modports: master = requester side, slave = responder side.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic [31:0] req_data;
  logic        req_read_write;
  logic [1:0]  req_access_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;

  modport master (
    output req_valid, req_address, req_data, req_read_write, req_access_size, req_unsigned,
    output resp_ready,
    input  req_ready, resp_valid, resp_data, resp_error
  );

  modport slave (
    input  req_valid, req_address, req_data, req_read_write, req_access_size, req_unsigned,
    input  resp_ready,
    output req_ready, resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency memory-side responder for the core's data-memory port.
// Accepts one load/store at a time, performs a byte/halfword/word access on an internal
// word-organised RAM LATENCY cycles after acceptance and returns extended load data or a
// store completion, with an error flag for misaligned, out-of-range or illegal-size requests.
// Ports:
//   i_clock : sole clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : dmem_responder_if.slave (request and response channels)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input logic             i_clock,
  input logic             i_reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned AddrBits  = $clog2(DEPTH_WORDS) + 2;
  localparam logic [32:0] SpanBytes = 33'(DEPTH_WORDS) << 2;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_rw;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_resp_error;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic                w_accept;
  logic                w_do_access;
  logic [31:0]         w_addr;
  logic [31:0]         w_wdata;
  logic                w_rw;
  logic [1:0]          w_size;
  logic                w_uns;
  logic [31:0]         w_off;
  logic                w_err;
  logic [AddrBits-3:0] w_idx;
  logic [31:0]         w_rd_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [31:0]         w_resp_data;
  logic [3:0]          w_be;
  logic [31:0]         w_wr_word;

  assign bus.req_ready = (r_state == StIdle) && !i_reset;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_do_access   = ((r_state == StIdle) && w_accept && (LATENCY == 1)) ||
                         ((r_state == StWait) && (r_cnt == 4'd0));

  // With LATENCY == 1 the access happens on the acceptance edge, so it uses the live request.
  assign w_addr  = (r_state == StIdle) ? bus.req_address     : r_addr;
  assign w_wdata = (r_state == StIdle) ? bus.req_data        : r_data;
  assign w_rw    = (r_state == StIdle) ? bus.req_read_write  : r_rw;
  assign w_size  = (r_state == StIdle) ? bus.req_access_size : r_size;
  assign w_uns   = (r_state == StIdle) ? bus.req_unsigned    : r_uns;

  assign w_off = w_addr - BASE_ADDR;
  assign w_err = ({1'b0, w_off} >= SpanBytes) || (w_size == 2'b11) ||
                 ((w_size == 2'b01) && w_off[0]) ||
                 ((w_size == 2'b10) && (w_off[1:0] != 2'b00));
  assign w_idx = w_off[AddrBits-1:2];

  assign w_rd_word = r_mem[w_idx];
  assign w_byte    = w_rd_word[{w_off[1:0], 3'b000} +: 8];
  assign w_half    = w_rd_word[{w_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load = w_rd_word;
    case (w_size)
      2'b00:   w_load = w_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = w_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_rd_word;
    endcase
  end

  assign w_resp_data = (w_err || !w_rw) ? 32'h0 : w_load;

  // Narrow store data is replicated across lanes so the byte enables alone select the target.
  always_comb begin
    w_be      = 4'b0000;
    w_wr_word = 32'h0;
    case (w_size)
      2'b00: begin
        w_be      = 4'b0001 << w_off[1:0];
        w_wr_word = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be      = w_off[1] ? 4'b1100 : 4'b0011;
        w_wr_word = {2{w_wdata[15:0]}};
      end
      2'b10: begin
        w_be      = 4'b1111;
        w_wr_word = w_wdata;
      end
      default: begin
        w_be      = 4'b0000;
        w_wr_word = 32'h0;
      end
    endcase
  end

  // RAM has no reset; a reset on the commit edge drops the pending store.
  always_ff @(posedge i_clock) begin
    if (w_do_access && !i_reset && !w_err && !w_rw) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wr_word[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0;
      r_resp_error <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_addr <= bus.req_address;
            r_data <= bus.req_data;
            r_rw   <= bus.req_read_write;
            r_size <= bus.req_access_size;
            r_uns  <= bus.req_unsigned;
            if (LATENCY == 1) begin
              r_state      <= StResp;
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_resp_data;
              r_resp_error <= w_err;
            end else begin
              r_cnt   <= 4'(LATENCY - 2);
              r_state <= StWait;
            end
          end
        end
        StWait: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state      <= StResp;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_resp_data;
            r_resp_error <= w_err;
          end
        end
        StResp: begin
          if (bus.resp_ready) begin
            r_state      <= StIdle;
            r_resp_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_error = r_resp_error;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: self-checking bench for dmem_responder. Three instances share a clock:
// inst 0 LATENCY=2 base 0, inst 1 LATENCY=4 base 0, inst 2 LATENCY=1 base 0x2000.
// A byte-array model computes expected load data, errors and store effects.
module tb_dmem_responder;
  localparam int unsigned Depth = 64;
  localparam int          NInst = 3;
  localparam int          Guard = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst       [NInst];
  logic        q_valid   [NInst];
  logic        q_rw      [NInst];
  logic        q_uns     [NInst];
  logic [1:0]  q_size    [NInst];
  logic [31:0] q_addr    [NInst];
  logic [31:0] q_data    [NInst];
  logic        p_ready   [NInst];
  logic        rdy       [NInst];
  logic        rsp_valid [NInst];
  logic        rsp_err   [NInst];
  logic [31:0] rsp_data  [NInst];

  for (genvar g = 0; g < NInst; g++) begin : g_inst
    localparam int unsigned Lat  = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
    localparam logic [31:0] Base = (g == 2) ? 32'h2000 : 32'h0;
    dmem_responder_if bus ();
    assign bus.req_valid       = q_valid[g];
    assign bus.req_address     = q_addr[g];
    assign bus.req_data        = q_data[g];
    assign bus.req_read_write  = q_rw[g];
    assign bus.req_access_size = q_size[g];
    assign bus.req_unsigned    = q_uns[g];
    assign bus.resp_ready      = p_ready[g];
    assign rdy[g]              = bus.req_ready;
    assign rsp_valid[g]        = bus.resp_valid;
    assign rsp_data[g]         = bus.resp_data;
    assign rsp_err[g]          = bus.resp_error;
    dmem_responder #(.DEPTH_WORDS(Depth), .BASE_ADDR(Base), .LATENCY(Lat)) u_dut (
      .i_clock(clk),
      .i_reset(rst[g]),
      .bus    (bus)
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? 32'h2000 : 32'h0;
  endfunction

  logic [7:0] mm [NInst][4*Depth];
  int n_vec = 0;
  int n_err = 0;
  int last_acc, last_rsp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory, natural alignment, little-endian assembly.
  task automatic model(input int k, input logic rw, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] exp_d, output logic exp_e);
    logic [31:0] off;
    logic [31:0] v;
    int n;
    off   = addr - base_of(k);
    n     = 1 << sz;
    exp_e = (off >= 4 * Depth) || (sz == 2'b11) || ((off % 32'(n)) != 0);
    exp_d = 32'h0;
    if (!exp_e) begin
      if (rw) begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[k][off + 32'(i)]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        exp_d = v;
      end else begin
        for (int i = 0; i < n; i++) mm[k][off + 32'(i)] = wdata[8*i +: 8];
      end
    end
  endtask

  task automatic xact(input int k, input logic rw, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic rerr);
    int guard;
    rdata = 32'h0;
    rerr  = 1'b0;
    @(negedge clk);
    q_valid[k] = 1'b1; q_rw[k] = rw; q_size[k] = sz; q_uns[k] = uns;
    q_addr[k] = addr; q_data[k] = wdata; p_ready[k] = 1'b1;
    guard = 0;
    while (!rdy[k] && guard < Guard) begin @(negedge clk); guard++; end
    if (!rdy[k]) begin
      check("accept timeout", 32'(rdy[k]), 32'd1);
      q_valid[k] = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    @(negedge clk);
    // Post-acceptance changes to request fields must not matter.
    q_valid[k] = 1'b0; q_rw[k] = 1'($urandom); q_size[k] = 2'($urandom);
    q_uns[k] = 1'($urandom); q_addr[k] = $urandom; q_data[k] = $urandom;
    guard = 0;
    while (!rsp_valid[k] && guard < Guard) begin @(negedge clk); guard++; end
    check("response timeout", 32'(rsp_valid[k]), 32'd1);
    last_rsp = cyc;
    rdata    = rsp_data[k];
    rerr     = rsp_err[k];
  endtask

  task automatic run(input int k, input logic rw, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                     output logic [31:0] rdata, output logic rerr);
    logic [31:0] exp_d;
    logic exp_e;
    model(k, rw, sz, uns, addr, wdata, exp_d, exp_e);
    xact(k, rw, sz, uns, addr, wdata, rdata, rerr);
    check({tag, " data"}, rdata, exp_d);
    check({tag, " err"}, 32'(rerr), 32'(exp_e));
    check({tag, " latency"}, 32'(last_rsp - last_acc + 1), 32'(lat_of(k)));
  endtask

  initial begin
    logic [31:0] d, exp_d;
    logic e, exp_e, seen;
    int guard, t_hs, r1, r2;

    for (int k = 0; k < NInst; k++) begin
      rst[k] = 1'b1; q_valid[k] = 1'b1; q_rw[k] = 1'b1; q_uns[k] = 1'b0;
      q_size[k] = 2'b10; q_addr[k] = 32'h0; q_data[k] = 32'h0; p_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NInst; k++) begin
      check("reset req_ready", 32'(rdy[k]), 32'd0);
      check("reset resp_valid", 32'(rsp_valid[k]), 32'd0);
      check("reset resp_data", rsp_data[k], 32'h0);
      check("reset resp_error", 32'(rsp_err[k]), 32'd0);
      q_valid[k] = 1'b0;
      rst[k]     = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < NInst; k++) check("idle req_ready", 32'(rdy[k]), 32'd1);

    // Word store then load.
    run(0, 1'b0, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, "st word 40", d, e);
    run(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, "ld word 40", d, e);
    check("ld word 40 value", d, 32'hDEADBEEF);

    // Narrow accesses.
    run(0, 1'b0, 2'b00, 1'b0, 32'h41, 32'h1234_5680, "st byte 41", d, e);
    run(0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h0, "ld byte s 41", d, e);
    check("ld byte s 41 value", d, 32'hFFFFFF80);
    run(0, 1'b1, 2'b00, 1'b1, 32'h41, 32'h0, "ld byte u 41", d, e);
    check("ld byte u 41 value", d, 32'h00000080);
    run(0, 1'b1, 2'b01, 1'b0, 32'h40, 32'h0, "ld half s 40", d, e);
    check("ld half s 40 value", d, 32'hFFFF80EF);
    run(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, "ld word 40 after byte", d, e);
    check("word 40 after byte", d, 32'hDEAD80EF);

    // Error cases leave RAM untouched.
    run(0, 1'b0, 2'b01, 1'b0, 32'h43, 32'hFFFF_FFFF, "st half 43", d, e);
    check("st half 43 error", 32'(e), 32'd1);
    run(0, 1'b1, 2'b10, 1'b0, 32'(4 * Depth), 32'h0, "ld word oor", d, e);
    check("ld word oor error", 32'(e), 32'd1);
    run(0, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, "illegal size", d, e);
    check("illegal size error", 32'(e), 32'd1);
    run(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, "ld word 40 after errs", d, e);
    check("word 40 after errs", d, 32'hDEAD80EF);

    // Backpressure: response held, second request waits for the handshake.
    model(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, exp_d, exp_e);
    @(negedge clk);
    q_valid[0] = 1'b1; q_rw[0] = 1'b1; q_size[0] = 2'b10; q_uns[0] = 1'b0;
    q_addr[0] = 32'h40; p_ready[0] = 1'b0;
    guard = 0;
    while (!rdy[0] && guard < Guard) begin @(negedge clk); guard++; end
    @(negedge clk);
    guard = 0;
    while (!rsp_valid[0] && guard < Guard) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      check("bp resp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp resp_data", rsp_data[0], exp_d);
      check("bp resp_error", 32'(rsp_err[0]), 32'(exp_e));
      check("bp req_ready", 32'(rdy[0]), 32'd0);
      @(negedge clk);
    end
    p_ready[0] = 1'b1;
    t_hs = cyc + 1;
    @(negedge clk);
    check("bp req_ready after hs", 32'(rdy[0]), 32'd1);
    check("bp resp_valid after hs", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    q_valid[0] = 1'b0;
    guard = 0;
    while (!rsp_valid[0] && guard < Guard) begin @(negedge clk); guard++; end
    check("bp 2nd resp cycle", 32'(cyc), 32'(t_hs + 2));
    check("bp 2nd resp data", rsp_data[0], exp_d);

    // Fill inst 0, then random traffic against the model.
    for (int w = 0; w < int'(Depth); w++) run(0, 1'b0, 2'b10, 1'b0, 32'(4 * w), $urandom, "fill", d, e);
    for (int i = 0; i < 120; i++) begin
      run(0, 1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 280)), $urandom,
          "random", d, e);
    end

    // Reset during WAIT drops the store (LATENCY=4).
    run(1, 1'b0, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D, "l4 st 80", d, e);
    @(negedge clk);
    q_valid[1] = 1'b1; q_rw[1] = 1'b0; q_size[1] = 2'b10; q_addr[1] = 32'h80;
    q_data[1] = 32'h12345678; p_ready[1] = 1'b1;
    guard = 0;
    while (!rdy[1] && guard < Guard) begin @(negedge clk); guard++; end
    @(negedge clk);
    q_valid[1] = 1'b0;
    rst[1]     = 1'b1;
    @(negedge clk);
    check("l4 ready in reset", 32'(rdy[1]), 32'd0);
    rst[1] = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid[1]) seen = 1'b1;
      @(negedge clk);
    end
    check("l4 dropped store no resp", 32'(seen), 32'd0);
    run(1, 1'b1, 2'b10, 1'b0, 32'h80, 32'h0, "l4 ld 80", d, e);
    check("l4 ld 80 old value", d, 32'hCAFEF00D);

    // LATENCY=1 back-to-back, base 0x2000.
    run(2, 1'b0, 2'b10, 1'b0, 32'h2010, 32'hA5A5_1234, "l1 st", d, e);
    run(2, 1'b1, 2'b10, 1'b0, 32'h2010, 32'h0, "l1 ld a", d, e);
    r1 = last_rsp;
    run(2, 1'b1, 2'b01, 1'b0, 32'h2012, 32'h0, "l1 ld b", d, e);
    r2 = last_rsp;
    check("l1 ld b value", d, 32'hFFFFA5A5);
    check("l1 spacing", 32'(r2 - r1), 32'd2);
    run(2, 1'b1, 2'b10, 1'b0, 32'h1FFC, 32'h0, "l1 below base", d, e);
    check("l1 below base error", 32'(e), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
